pps_conditioner: RTL and testbench

Parametrised PPS conditioner for the TURF trigger/timing path. It synchronises the GPS PPS input into a single clock domain and edge-detects it with selectable polarity. It enforces a programmable holdoff, measures the cycle count between consecutive external pulses, and optionally flywheels synthetic pulses when the external PPS disappears. One instance is used per consuming clock domain, and it emits a single-cycle pulse plus status to the event-timestamp and trigger logic.

---
 rtl/pps_conditioner.sv | 87 ++++++++
 tb/tb_pps_conditioner.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pps_conditioner.sv
// pps_conditioner: synchronises and edge-detects PPS, enforces holdoff, measures period
// and flywheels synthetic pulses when the external reference disappears.
module pps_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 28,
    parameter int HOLDOFF     = 32768,
    parameter int TOLERANCE   = 1024,
    parameter int POLARITY    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 pps_i,
    input  logic                 mode_i,
    input  logic [CNT_WIDTH-1:0] nominal_period_i,
    output logic                 pps_o,
    output logic                 pps_ext_o,
    output logic [CNT_WIDTH-1:0] period_o,
    output logic                 period_update_o,
    output logic [1:0]           state_o,
    output logic [7:0]           missed_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, LOCKED = 2'd1, FLYWHEEL = 2'd2} state_t;
    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   pps_pol;
    logic                   accept;
    logic                   timeout;
    logic                   synth;
    logic [CNT_WIDTH:0]     limit;
    logic [7:0]             missed_inc;
    // Inverting before the chain lets a single rising-edge detector serve both polarities.
    assign pps_pol    = (POLARITY != 0) ? pps_i : ~pps_i;
    assign limit      = {1'b0, nominal_period_i} + (CNT_WIDTH+1)'(TOLERANCE);
    assign accept     = sync[SYNC_STAGES-1] && !hist && (cnt >= CNT_WIDTH'(HOLDOFF) || state == IDLE);
    assign timeout    = state == LOCKED && {1'b0, cnt} == limit;
    assign synth      = state == FLYWHEEL && cnt == nominal_period_i;
    assign missed_inc = missed_o + {7'd0, missed_o != 8'hFF};
    assign state_o    = state;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync            <= '0;
            hist            <= 1'b0;
            cnt             <= '0;
            state           <= IDLE;
            pps_o           <= 1'b0;
            pps_ext_o       <= 1'b0;
            period_o        <= '0;
            period_update_o <= 1'b0;
            missed_o        <= 8'd0;
        end else begin
            sync            <= {sync[SYNC_STAGES-2:0], pps_pol};
            hist            <= sync[SYNC_STAGES-1];
            pps_o           <= 1'b0;
            pps_ext_o       <= 1'b0;
            period_update_o <= 1'b0;
            cnt             <= (&cnt) ? cnt : cnt + 1'b1;
            // External edge outranks timeout and synthetic pulses in the same cycle.
            if (accept) begin
                pps_o     <= 1'b1;
                pps_ext_o <= 1'b1;
                cnt       <= CNT_WIDTH'(1);
                state     <= LOCKED;
                if (state == LOCKED) begin
                    period_o        <= cnt;
                    period_update_o <= 1'b1;
                end
            end else if (timeout) begin
                missed_o <= missed_inc;
                if (mode_i) begin
                    pps_o <= 1'b1;
                    cnt   <= CNT_WIDTH'(1);
                    state <= FLYWHEEL;
                end else begin
                    state <= IDLE;
                end
            end else if (state == FLYWHEEL && !mode_i) begin
                state <= IDLE;
            end else if (synth) begin
                pps_o    <= 1'b1;
                cnt      <= CNT_WIDTH'(1);
                missed_o <= missed_inc;
            end
        end
    end
endmodule

// File: tb/tb_pps_conditioner.sv
// tb_pps_conditioner: directed checks of latency, period, holdoff, flywheel, timeout,
// reset and inverted polarity with hand-computed expectations.
module tb_pps_conditioner;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pps_i = 1'b0;
    logic        pps_n = 1'b1;
    logic        mode_i = 1'b1;
    logic [27:0] nominal = 28'd1000;
    logic        pps_o, pps_ext_o, period_update_o;
    logic [27:0] period_o;
    logic [1:0]  state_o;
    logic [7:0]  missed_o;
    logic        n_pps_o, n_pps_ext_o, n_period_update_o;
    logic [27:0] n_period_o;
    logic [1:0]  n_state_o;
    logic [7:0]  n_missed_o;
    int          checks = 0;
    int          errors = 0;
    int          npulse;

    always #2 clk = ~clk;

    pps_conditioner #(.SYNC_STAGES(2), .CNT_WIDTH(28), .HOLDOFF(100), .TOLERANCE(16), .POLARITY(1)) dut (
        .clk_i(clk), .rst_i(rst), .pps_i(pps_i), .mode_i(mode_i), .nominal_period_i(nominal),
        .pps_o(pps_o), .pps_ext_o(pps_ext_o), .period_o(period_o),
        .period_update_o(period_update_o), .state_o(state_o), .missed_o(missed_o));

    pps_conditioner #(.SYNC_STAGES(2), .CNT_WIDTH(28), .HOLDOFF(100), .TOLERANCE(16), .POLARITY(0)) dut_n (
        .clk_i(clk), .rst_i(rst), .pps_i(pps_n), .mode_i(mode_i), .nominal_period_i(nominal),
        .pps_o(n_pps_o), .pps_ext_o(n_pps_ext_o), .period_o(n_period_o),
        .period_update_o(n_period_update_o), .state_o(n_state_o), .missed_o(n_missed_o));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Rise captured on the next edge; pps_o, if accepted, is visible after the third edge.
    task automatic ext_pulse();
        pps_i = 1'b1;
        tick(1);
        pps_i = 1'b0;
        tick(2);
    endtask

    task automatic after_pulse();
        tick(1);
        chk("pulse_width", pps_o, 0);
        chk("upd_width", period_update_o, 0);
    endtask

    // Called one cycle after a pulse; next pps_o lands n cycles after that pulse.
    task automatic ext_after(input int n);
        tick(n - 4);
        ext_pulse();
    endtask

    initial begin
        tick(3);
        chk("rst_pps", pps_o, 0);
        chk("rst_ext", pps_ext_o, 0);
        chk("rst_state", state_o, 0);
        chk("rst_period", period_o, 0);
        chk("rst_upd", period_update_o, 0);
        chk("rst_missed", missed_o, 0);
        chk("rst_n_pps", n_pps_o, 0);
        rst = 1'b0;
        pps_i = 1'b1;
        tick(1);
        chk("lat_k", pps_o, 0);
        tick(1);
        chk("lat_k1", pps_o, 0);
        tick(1);
        pps_i = 1'b0;
        chk("lat_k2", pps_o, 1);
        chk("first_ext", pps_ext_o, 1);
        chk("first_state", state_o, 1);
        chk("first_noupd", period_update_o, 0);
        chk("first_missed", missed_o, 0);
        after_pulse();
        ext_after(1000);
        chk("p1000_pps", pps_o, 1);
        chk("p1000_upd", period_update_o, 1);
        chk("p1000_val", period_o, 1000);
        after_pulse();
        ext_after(1003);
        chk("p1003_upd", period_update_o, 1);
        chk("p1003_val", period_o, 1003);
        after_pulse();
        ext_after(50);
        chk("holdoff50_drop", pps_o, 0);
        tick(47);
        ext_pulse();
        chk("holdoff100_acc", pps_o, 1);
        chk("holdoff100_per", period_o, 100);
        after_pulse();
        ext_after(99);
        chk("holdoff99_drop", pps_o, 0);
        tick(48);
        ext_pulse();
        chk("p150_pps", pps_o, 1);
        chk("p150_val", period_o, 150);
        after_pulse();
        tick(1014);
        chk("fw_pre_pps", pps_o, 0);
        chk("fw_pre_state", state_o, 1);
        tick(1);
        chk("fw1_pps", pps_o, 1);
        chk("fw1_ext", pps_ext_o, 0);
        chk("fw1_state", state_o, 2);
        chk("fw1_missed", missed_o, 1);
        chk("fw1_noupd", period_update_o, 0);
        after_pulse();
        tick(998);
        chk("fw2_pre", pps_o, 0);
        tick(1);
        chk("fw2_pps", pps_o, 1);
        chk("fw2_ext", pps_ext_o, 0);
        chk("fw2_missed", missed_o, 2);
        after_pulse();
        ext_after(500);
        chk("ret_pps", pps_o, 1);
        chk("ret_ext", pps_ext_o, 1);
        chk("ret_state", state_o, 1);
        chk("ret_noupd", period_update_o, 0);
        chk("ret_period", period_o, 150);
        after_pulse();
        ext_after(1000);
        chk("ret2_upd", period_update_o, 1);
        chk("ret2_val", period_o, 1000);
        mode_i = 1'b0;
        after_pulse();
        tick(1014);
        chk("to_pre_state", state_o, 1);
        tick(1);
        chk("to_pps", pps_o, 0);
        chk("to_state", state_o, 0);
        chk("to_missed", missed_o, 3);
        ext_pulse();
        chk("idle_acc_pps", pps_o, 1);
        chk("idle_acc_state", state_o, 1);
        chk("idle_acc_noupd", period_update_o, 0);
        after_pulse();
        ext_after(1016);
        chk("tie_pps", pps_o, 1);
        chk("tie_ext", pps_ext_o, 1);
        chk("tie_state", state_o, 1);
        chk("tie_missed", missed_o, 3);
        chk("tie_period", period_o, 1016);
        mode_i = 1'b1;
        after_pulse();
        tick(1015);
        chk("rfw_pps", pps_o, 1);
        chk("rfw_state", state_o, 2);
        chk("rfw_missed", missed_o, 4);
        tick(500);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rfw_rst_pps", pps_o, 0);
        chk("rfw_rst_state", state_o, 0);
        chk("rfw_rst_missed", missed_o, 0);
        chk("rfw_rst_period", period_o, 0);
        chk("rfw_rst_ext", pps_ext_o, 0);
        npulse = 0;
        for (int i = 0; i < 1200; i++) begin
            tick(1);
            if (pps_o) npulse++;
        end
        chk("rfw_no_synth", npulse, 0);
        chk("rfw_idle", state_o, 0);
        chk("neg_idle", n_state_o, 0);
        pps_n = 1'b0;
        tick(3);
        chk("neg_fall_pps", n_pps_o, 1);
        chk("neg_fall_ext", n_pps_ext_o, 1);
        chk("neg_fall_state", n_state_o, 1);
        tick(200);
        pps_n = 1'b1;
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (n_pps_o) npulse++;
        end
        chk("neg_rise_none", npulse, 0);
        chk("neg_rise_state", n_state_o, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
